// File: rtl/filter_op_sequencer_if.sv
// Window/result/write-back handshake between the operation sequencer and the
// filter datapath. The sequencer takes the master side.
interface filter_op_sequencer_if;
    logic [4:0] win_row;
    logic [4:0] win_col;
    logic       win_valid;
    logic       win_ready;
    logic       res_valid;
    logic       wb_start;
    logic       wb_done;

    modport master (
        output win_row, win_col, win_valid, wb_start,
        input  win_ready, res_valid, wb_done
    );

    modport slave (
        input  win_row, win_col, win_valid, wb_start,
        output win_ready, res_valid, wb_done
    );
endinterface

// File: rtl/filter_op_sequencer.sv
// Steps the pixel datapath through the EDGE or COLOR operation chain, scanning
// window centres per operation. Define SEQ_STALL_CNT_EN to add the stall counter.
module filter_op_sequencer #(
    parameter int IMG_DIM   = 20,
    parameter int MAX_OUTST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    output logic [2:0]            op,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           stall_cnt,
    filter_op_sequencer_if.master dp
);

    localparam logic [2:0] OP_MED   = 3'd0;
    localparam logic [2:0] OP_GAU   = 3'd1;
    localparam logic [2:0] OP_HYST  = 3'd4;
    localparam logic [2:0] OP_QUANT = 3'd5;
    localparam logic [2:0] OUTST_MAX = 3'(MAX_OUTST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_OP,
        S_SCAN,
        S_DRAIN,
        S_WRITE_BACK,
        S_FINISH
    } state_t;

    state_t     state, state_nxt;
    logic       mode_q, mode_nxt;
    logic [2:0] op_nxt;
    logic [4:0] row_nxt, col_nxt;
    logic       win_valid_nxt, wb_start_nxt, busy_nxt, done_nxt, err_nxt;
    logic [2:0] outst, outst_nxt;

    logic [4:0] r, lim;
    logic       transfer, res_ok, res_bad, wb_bad, start_acc;
    logic       last_col, last_win, chain_last;

    // Filter footprint radius: the 5x5 Gaussian needs a 2-pixel border,
    // quantisation is per-pixel, everything else is a 3x3 window.
    function automatic logic [4:0] radius(input logic [2:0] o);
        if (o == OP_GAU)
            radius = 5'd2;
        else if (o == OP_QUANT)
            radius = 5'd0;
        else
            radius = 5'd1;
    endfunction

    function automatic logic [2:0] next_op(input logic [2:0] o, input logic m);
        if (m)
            next_op = OP_QUANT;
        else
            next_op = 3'(o + 3'd1);
    endfunction

    function automatic logic is_last_op(input logic [2:0] o, input logic m);
        is_last_op = m ? (o == OP_QUANT) : (o == OP_HYST);
    endfunction

    assign r          = radius(op);
    assign lim        = 5'(IMG_DIM - 1) - r;
    assign last_col   = (dp.win_col == lim);
    assign last_win   = last_col && (dp.win_row == lim);
    assign chain_last = is_last_op(op, mode_q);
    assign start_acc  = (state == S_IDLE) && start;

    assign transfer = (state == S_SCAN) && dp.win_valid && dp.win_ready;
    // A result is only legitimate against an in-flight window (or one leaving now).
    assign res_ok   = ((state == S_SCAN) || (state == S_DRAIN)) && dp.res_valid
                      && ((outst != 3'd0) || transfer);
    assign res_bad  = dp.res_valid && (outst == 3'd0) && !transfer;
    assign wb_bad   = dp.wb_done && (state != S_WRITE_BACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            mode_q       <= 1'b0;
            op           <= OP_MED;
            dp.win_row   <= '0;
            dp.win_col   <= '0;
            dp.win_valid <= 1'b0;
            dp.wb_start  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            outst        <= '0;
        end else begin
            state        <= state_nxt;
            mode_q       <= mode_nxt;
            op           <= op_nxt;
            dp.win_row   <= row_nxt;
            dp.win_col   <= col_nxt;
            dp.win_valid <= win_valid_nxt;
            dp.wb_start  <= wb_start_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
            outst        <= outst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (start) state_nxt = S_SET_OP;
            S_SET_OP:     state_nxt = S_SCAN;
            S_SCAN:       if (transfer && last_win) state_nxt = S_DRAIN;
            S_DRAIN:      if (outst == 3'd0) state_nxt = chain_last ? S_FINISH : S_WRITE_BACK;
            S_WRITE_BACK: if (dp.wb_done) state_nxt = S_SET_OP;
            S_FINISH:     state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mode_nxt = mode_q;
        op_nxt   = op;
        row_nxt  = dp.win_row;
        col_nxt  = dp.win_col;
        case (state)
            S_IDLE: begin
                if (start) begin
                    mode_nxt = mode;
                    op_nxt   = OP_MED;
                end
            end
            S_SET_OP: begin
                row_nxt = r;
                col_nxt = r;
            end
            S_SCAN: begin
                // The final centre is held; SET_OP reloads for the next operation.
                if (transfer && !last_win) begin
                    if (last_col) begin
                        col_nxt = r;
                        row_nxt = dp.win_row + 5'd1;
                    end else begin
                        col_nxt = dp.win_col + 5'd1;
                    end
                end
            end
            S_WRITE_BACK: begin
                if (dp.wb_done) op_nxt = next_op(op, mode_q);
            end
            default: ;
        endcase

        outst_nxt = outst;
        if (transfer && !res_ok)
            outst_nxt = outst + 3'd1;
        else if (!transfer && res_ok)
            outst_nxt = outst - 3'd1;

        err_nxt = (start_acc ? 1'b0 : err) | res_bad | wb_bad;

        // Driven from the next outstanding count so a retiring result re-opens
        // the window one cycle later rather than combinationally.
        win_valid_nxt = (state_nxt == S_SCAN) && (outst_nxt != OUTST_MAX);
        wb_start_nxt  = (state == S_DRAIN) && (state_nxt == S_WRITE_BACK);
        busy_nxt      = (state_nxt != S_IDLE);
        done_nxt      = (state_nxt == S_FINISH);
    end

`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= '0;
        else if (start_acc)
            stall_q <= '0;
        else if (dp.win_valid && !dp.win_ready && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_filter_op_sequencer.sv
// Directed bench for filter_op_sequencer: full COLOR/EDGE chains, backpressure,
// outstanding limit, protocol errors and mid-run reset.
module tb_filter_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [2:0]  op;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] stall_cnt;

    filter_op_sequencer_if bus ();

    filter_op_sequencer #(.IMG_DIM(20), .MAX_OUTST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .stall_cnt (stall_cnt),
        .dp        (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // run statistics
    int win_cnt  [8];
    int first_rc [8];
    int last_rc  [8];
    int mism, wb_cnt, done_cnt, hold_bad, op_code;
    bit err_seen, finished, aborted;
    logic post_busy, post_done;

`ifdef SEQ_STALL_CNT_EN
    localparam int EXP_STALL = 5;
`else
    localparam int EXP_STALL = 0;
`endif

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic do_start(input bit m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Responder: win_ready high (optionally 5 stall cycles at MED_FIL (1,7)),
    // res_valid one cycle after each transfer, wb_done two cycles after wb_start.
    // A bench-side scan model checks every issued centre.
    task automatic run_chain(input bit do_bp, input bit abort_en);
        int  exp_r, exp_row, exp_col, cur_op, bp_left, wb_delay;
        bit  xfer_prev, bp_used;
        exp_r = 0; exp_row = 0; exp_col = 0; cur_op = -1;
        bp_left = 0; wb_delay = 0; xfer_prev = 0; bp_used = 0;
        for (int i = 0; i < 8; i++) begin
            win_cnt[i] = 0; first_rc[i] = -1; last_rc[i] = -1;
        end
        mism = 0; wb_cnt = 0; done_cnt = 0; hold_bad = 0; op_code = 0;
        err_seen = 0; finished = 0; aborted = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(posedge clk); #1;
            bus.res_valid = xfer_prev;
            if (wb_delay > 0) begin
                wb_delay--;
                bus.wb_done = (wb_delay == 0);
            end else begin
                bus.wb_done = 1'b0;
            end
            if (bus.wb_start) begin
                wb_cnt++;
                wb_delay = 2;
            end
            if (err) err_seen = 1;
            if (done) begin
                done_cnt++;
                finished = 1;
                break;
            end
            if (abort_en && bus.win_valid && op == 3'd2 && bus.win_row == 5'd9 && bus.win_col == 5'd4) begin
                aborted = 1;
                break;
            end
            if (do_bp && !bp_used && bus.win_valid && op == 3'd0 && bus.win_row == 5'd1 && bus.win_col == 5'd7) begin
                bp_left = 5;
                bp_used = 1;
            end
            if (bp_left > 0) begin
                bus.win_ready = 1'b0;
                bp_left--;
                if (!(bus.win_valid && bus.win_row == 5'd1 && bus.win_col == 5'd7)) hold_bad++;
            end else begin
                bus.win_ready = 1'b1;
            end
            xfer_prev = bus.win_valid && bus.win_ready;
            if (xfer_prev) begin
                if (int'(op) != cur_op) begin
                    cur_op  = op;
                    op_code = op_code * 10 + int'(op) + 1;
                    exp_r   = (op == 3'd1) ? 2 : (op == 3'd5) ? 0 : 1;
                    exp_row = exp_r;
                    exp_col = exp_r;
                    first_rc[op] = int'(bus.win_row) * 32 + int'(bus.win_col);
                end
                if (int'(bus.win_row) != exp_row || int'(bus.win_col) != exp_col) mism++;
                win_cnt[op]++;
                last_rc[op] = int'(bus.win_row) * 32 + int'(bus.win_col);
                if (exp_col == 19 - exp_r) begin
                    exp_col = exp_r;
                    exp_row++;
                end else begin
                    exp_col++;
                end
            end
        end
        bus.res_valid = 1'b0;
        bus.wb_done   = 1'b0;
        bus.win_ready = 1'b1;
        post_busy = 1'bx;
        post_done = 1'bx;
        if (finished) begin
            @(posedge clk); #1;
            post_busy = busy;
            post_done = done;
        end
    endtask

    initial begin
        int  n;
        bit  reached, found;

        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        bus.win_ready = 1'b1;
        bus.res_valid = 1'b0;
        bus.wb_done   = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_op",        int'(op), 0);
        check("rst_win_row",   int'(bus.win_row), 0);
        check("rst_win_col",   int'(bus.win_col), 0);
        check("rst_win_valid", int'(bus.win_valid), 0);
        check("rst_wb_start",  int'(bus.wb_start), 0);
        check("rst_busy",      int'(busy), 0);
        check("rst_done",      int'(done), 0);
        check("rst_err",       int'(err), 0);
        check("rst_stall_cnt", int'(stall_cnt), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // COLOR chain: MED_FIL then QUANTIZE
        do_start(1'b1);
        check("color_busy_after_start", int'(busy), 1);
        run_chain(1'b0, 1'b0);
        check("color_done_pulses", done_cnt, 1);
        check("color_op_seq",      op_code, 16);
        check("color_med_count",   win_cnt[0], 324);
        check("color_med_first",   first_rc[0], 1 * 32 + 1);
        check("color_med_last",    last_rc[0], 18 * 32 + 18);
        check("color_quant_count", win_cnt[5], 400);
        check("color_quant_first", first_rc[5], 0);
        check("color_quant_last",  last_rc[5], 19 * 32 + 19);
        check("color_scan_order",  mism, 0);
        check("color_wb_pulses",   wb_cnt, 1);
        check("color_err_seen",    int'(err_seen), 0);
        check("color_busy_end",    int'(post_busy), 0);
        check("color_done_width",  int'(post_done), 0);

        // Unsolicited result in IDLE
        bus.res_valid = 1'b1;
        @(posedge clk); #1;
        bus.res_valid = 1'b0;
        check("idle_res_err", int'(err), 1);

        // EDGE chain with backpressure at MED_FIL (1,7)
        do_start(1'b0);
        check("start_clears_err", int'(err), 0);
        run_chain(1'b1, 1'b0);
        check("edge_done_pulses", done_cnt, 1);
        check("edge_op_seq",      op_code, 12345);
        check("edge_med_count",   win_cnt[0], 324);
        check("edge_gau_count",   win_cnt[1], 256);
        check("edge_gau_first",   first_rc[1], 2 * 32 + 2);
        check("edge_gau_last",    last_rc[1], 17 * 32 + 17);
        check("edge_sobel_count", win_cnt[2], 324);
        check("edge_hyst_count",  win_cnt[4], 324);
        check("edge_scan_order",  mism, 0);
        check("edge_wb_pulses",   wb_cnt, 4);
        check("bp_hold_bad",      hold_bad, 0);
        check("edge_err_seen",    int'(err_seen), 0);
        check("edge_busy_end",    int'(post_busy), 0);
        check("bp_stall_cnt",     int'(stall_cnt), EXP_STALL);

        // Write-back done outside WRITE_BACK
        bus.wb_done = 1'b1;
        @(posedge clk); #1;
        bus.wb_done = 1'b0;
        check("idle_wb_done_err", int'(err), 1);

        // Outstanding limit: results withheld
        do_start(1'b1);
        bus.win_ready = 1'b1;
        bus.res_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.win_valid && bus.win_ready) n++;
            @(posedge clk); #1;
        end
        check("outst_transfers",  n, 4);
        check("outst_valid_low",  int'(bus.win_valid), 0);
        check("outst_held_row",   int'(bus.win_row), 1);
        check("outst_held_col",   int'(bus.win_col), 5);
        check("outst_no_err",     int'(err), 0);

        // start while busy, with the other mode, must be ignored
        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start_op",    int'(op), 0);
        check("busy_start_busy",  int'(busy), 1);

        bus.res_valid = 1'b1;
        @(posedge clk); #1;
        bus.res_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.win_valid && bus.win_ready) n++;
            @(posedge clk); #1;
        end
        check("outst_one_more",   n, 1);
        check("outst_next_col",   int'(bus.win_col), 6);

        // Keep 4 in flight up to the last MED_FIL centre
        reached = 0;
        for (int i = 0; i < 2000; i++) begin
            bus.res_valid = 1'b0;
            if (bus.win_valid && bus.win_ready && bus.win_row == 5'd18 && bus.win_col == 5'd18) begin
                reached = 1;
                break;
            end else if (!bus.win_valid) begin
                bus.res_valid = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.res_valid = 1'b0;
        check("outst_reached_last", int'(reached), 1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.wb_start || bus.win_valid) n++;
        end
        bus.res_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.wb_start) n++;
        end
        bus.res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.wb_start) n++;
        end
        check("drain_waits_all", n, 0);
        bus.res_valid = 1'b1;
        @(posedge clk); #1;
        bus.res_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.wb_start) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("drain_wb_start", int'(found), 1);
        // wb_done in the same cycle as wb_start
        bus.wb_done = 1'b1;
        @(posedge clk); #1;
        bus.wb_done = 1'b0;
        run_chain(1'b0, 1'b0);
        check("outst_quant_count", win_cnt[5], 400);
        check("outst_quant_seq",   op_code, 6);
        check("outst_quant_order", mism, 0);
        check("outst_done",        done_cnt, 1);
        check("outst_no_wb",       wb_cnt, 0);
        check("outst_err_seen",    int'(err_seen), 0);

        // Reset during SOBEL at (9,4)
        do_start(1'b0);
        run_chain(1'b0, 1'b1);
        check("abort_reached", int'(aborted), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.res_valid = 1'b0;
        bus.wb_done   = 1'b0;
        check("abort_busy",      int'(busy), 0);
        check("abort_win_valid", int'(bus.win_valid), 0);
        check("abort_op",        int'(op), 0);
        @(posedge clk); #1;
        do_start(1'b0);
        run_chain(1'b0, 1'b0);
        check("rerun_done",      done_cnt, 1);
        check("rerun_op_seq",    op_code, 12345);
        check("rerun_wb_pulses", wb_cnt, 4);
        check("rerun_order",     mism, 0);
        check("rerun_sobel",     win_cnt[2], 324);
        check("rerun_err_seen",  int'(err_seen), 0);
        check("rerun_busy_end",  int'(post_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/filter_op_sequencer.md
Name: filter_op_sequencer

Overview:
- Sequences the pixel-processing datapath after an image has been loaded into the register file.
- Steps through the operation chain selected by mode, one operation at a time. Edge chain: MED_FIL→GAU_FIL→SOBEL→NON_MAX→HYSTER. Color chain: MED_FIL→QUANTIZE.
- For each operation it raster-scans the valid window centres, issuing them to the filter datapath over a valid/ready handshake, and tracks in-flight results.
- Between operations it triggers the tmp→img write-back.

Parameters:
- IMG_DIM, 20, image side length in pixels.
- MAX_OUTST, 4, maximum windows accepted by the datapath but not yet returned (1..7).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  image loaded, begin the chain; sampled only in IDLE.
- mode  input  1  0=EDGE, 1=COLOR; captured on accepted start.
- op  output  3  current operation: MED_FIL=0, GAU_FIL=1, SOBEL=2, NON_MAX=3, HYSTER=4, QUANTIZE=5.
- win_row  output  5  window-centre row.
- win_col  output  5  window-centre column.
- win_valid  output  1  window coordinates valid.
- win_ready  input  1  datapath accepts a window.
- res_valid  input  1  datapath retired one result (1-cycle pulse per window).
- wb_start  output  1  1-cycle pulse: copy tmp to img.
- wb_done  input  1  write-back complete.
- busy  output  1  high in every state except IDLE.
- done  output  1  1-cycle pulse when the chain finishes.
- err  output  1  sticky protocol error.
- stall_cnt  output  16  handshake stall cycles (optional feature).

Behaviour:
- Reset: state=IDLE; op=0, win_row=0, win_col=0, win_valid=0, wb_start=0, busy=0, done=0, err=0, stall_cnt=0; outstanding counter=0.
- Reset asserted mid-operation aborts everything; the block is in IDLE after that edge.
- States:
  - IDLE: on start, capture mode, set op=MED_FIL, clear err, go to SET_OP. start is ignored in every other state.
  - SET_OP (1 cycle): compute radius r for op.
    - r=2 for GAU_FIL.
    - r=0 for QUANTIZE.
    - r=1 for all other operations.
    - Load win_row=r, win_col=r, then go to SCAN.
  - SCAN: win_valid=1 unless outstanding==MAX_OUTST.
    - Exception to the stall: if res_valid arrives that same cycle while outstanding==MAX_OUTST, win_valid stays 0 that cycle and rises next cycle.
    - Transfer occurs on win_valid&&win_ready.
    - While win_valid&&!win_ready, win_row and win_col are held.
    - After a transfer, win_col increments.
    - When win_col reaches IMG_DIM-1-r, win_col returns to r and win_row increments.
    - The transfer of the last centre (IMG_DIM-1-r, IMG_DIM-1-r) moves to DRAIN, with win_valid=0 in the next cycle.
  - DRAIN: wait until outstanding==0. Then:
    - if op is the last operation of the chain, go to FINISH;
    - otherwise go to WRITE_BACK with wb_start pulsed in the first cycle.
  - WRITE_BACK: wait for wb_done. Then advance op to the next operation of the chain and go to SET_OP. A wb_done in the same cycle as wb_start is accepted.
  - FINISH (1 cycle): done=1, then go to IDLE.
- The last operation (HYSTER or QUANTIZE) never gets a write-back.
- Window count per operation is (IMG_DIM-2r)²: GAU_FIL 256; MED_FIL/SOBEL/NON_MAX/HYSTER 324; QUANTIZE 400.
- Outstanding counter:
  - +1 on transfer, −1 on res_valid.
  - Simultaneous transfer and res_valid leaves it unchanged.
  - Width is 3 bits.
- err (sticky until next accepted start):
  - set if res_valid arrives with outstanding==0 and no simultaneous transfer; the counter does not underflow;
  - set if wb_done arrives outside WRITE_BACK.
- win_ready and res_valid are ignored outside SCAN/DRAIN. An unsolicited res_valid in those other states still sets err.
- All outputs are registered.

Optional Feature:
- Macro SEQ_STALL_CNT_EN.
- Defined:
  - stall_cnt increments each cycle win_valid&&!win_ready, saturating at 16'hFFFF;
  - cleared on accepted start;
  - holds its value through IDLE.
- Undefined: stall_cnt is tied to 0 and no counter logic is synthesised.

Test Plan:
- COLOR chain, win_ready=1, res_valid 1 cycle after each transfer:
  - 324 MED_FIL windows (1,1)..(18,18), then one wb_start;
  - after wb_done, 400 QUANTIZE windows (0,0)..(19,19);
  - then done pulse, busy=0, no second wb_start.
- EDGE chain, same responder:
  - op sequence 0,1,2,3,4;
  - GAU_FIL issues 256 windows starting (2,2) and ending (17,17);
  - exactly 4 wb_start pulses, then done.
- Backpressure: win_ready low for 5 cycles at window (1,7):
  - coordinates held at (1,7) throughout;
  - with SEQ_STALL_CNT_EN, stall_cnt=5 after the run.
- Outstanding limit: MAX_OUTST=4, datapath withholds res_valid:
  - win_valid drops after 4 transfers;
  - one res_valid lets exactly one more transfer;
  - DRAIN waits until all 4 are returned.
- Protocol errors:
  - res_valid in IDLE → err=1;
  - next start → err=0;
  - start while busy is ignored (op unchanged).
- Reset during SCAN of SOBEL at window (9,4):
  - next cycle busy=0, win_valid=0, op=0;
  - a new start runs the full chain correctly.
